// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the sequential multi-word adder: slice width and FSM encodings.
package multiword_add_seq_pkg;

    localparam int unsigned SliceW = 16;

    // 2'd3 is unused; the FSM recovers from it to StIdle.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/carry_skip_16bit.sv
// 16-bit carry-skip adder: four 4-bit ripple blocks, each bypassed when all its bits propagate.
module carry_skip_16bit
    import multiword_add_seq_pkg::*;
(
    input  logic [SliceW-1:0] a,
    input  logic [SliceW-1:0] b,
    input  logic              cin,
    output logic [SliceW-1:0] sum,
    output logic              cout
);

    logic [SliceW-1:0] p;
    logic [SliceW-1:0] g;
    logic [SliceW:0]   rc;
    logic [4:0]        bc;

    always_comb begin
        p     = a ^ b;
        g     = a & b;
        rc    = '0;
        bc    = '0;
        bc[0] = cin;
        for (int blk = 0; blk < 4; blk++) begin
            rc[4*blk] = bc[blk];
            for (int i = 0; i < 4; i++) begin
                rc[4*blk+i+1] = g[4*blk+i] | (p[4*blk+i] & rc[4*blk+i]);
            end
            // Block carry skips straight across when every bit propagates.
            bc[blk+1] = (&p[4*blk +: 4]) ? bc[blk] : rc[4*blk+4];
        end
        sum  = p ^ rc[SliceW-1:0];
        cout = bc[4];
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Adds two WORDS x 16-bit operands one slice per cycle through a single 16-bit adder.
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SliceW*WORDS-1:0] a,
    input  logic [SliceW*WORDS-1:0] b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [SliceW*WORDS-1:0] sum,
    output logic                  cout,
    output logic                  overflow
);

    localparam int unsigned W    = SliceW * WORDS;
    localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_e            state;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic              carry_q;
    logic [IdxW-1:0]   idx_q;

    logic [SliceW-1:0] add_a;
    logic [SliceW-1:0] add_b;
    logic [SliceW-1:0] add_sum;
    logic              add_cout;
    logic              last;

    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int i = 0; i < int'(WORDS); i++) begin
            if (idx_q == IdxW'(i)) begin
                add_a = a_q[i*SliceW +: SliceW];
                add_b = b_q[i*SliceW +: SliceW];
            end
        end
    end

    assign last = (idx_q == IdxW'(WORDS - 1));

    carry_skip_16bit u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry_q  <= cin;
                        idx_q    <= '0;
                        sum      <= '0;
                        cout     <= 1'b0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        state    <= StRun;
                    end
                end
                StRun: begin
                    for (int i = 0; i < int'(WORDS); i++) begin
                        if (idx_q == IdxW'(i)) begin
                            sum[i*SliceW +: SliceW] <= add_sum;
                        end
                    end
                    carry_q <= add_cout;
                    if (last) begin
                        // add_sum[15] is the top bit of the final W-bit sum.
                        cout     <= add_cout;
                        overflow <= (a_q[W-1] == b_q[W-1]) && (add_sum[SliceW-1] != a_q[W-1]);
                        idx_q    <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= StDone;
                    end else begin
                        idx_q <= idx_q + IdxW'(1);
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
